// File: rtl/dmem_arb_pkg.sv
// Shared types and default geometry for the data-memory arbiter.
// Holds the FSM state encoding, the parity region bounds and the starvation limit.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_CPU_LOCK  = 2'd1,
        ARB_HOST_LOCK = 2'd2
    } arb_state_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int PAR_LO_DEF     = 64;
    localparam int PAR_HI_DEF     = 127;

endpackage

// File: rtl/dmem_parity_chk.sv
// Parity check of reads from the protected region of data memory.
// Flags odd-parity reads one cycle after the grant and keeps a saturating error log.
module dmem_parity_chk
    import dmem_arb_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int PAR_LO = PAR_LO_DEF,
    parameter int PAR_HI = PAR_HI_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    output logic          ParityErr,
    output logic [AW-1:0] ErrAddr,
    output logic [7:0]    ErrCount
);

    localparam logic [AW-1:0] LO = AW'(PAR_LO);
    localparam logic [AW-1:0] HI = AW'(PAR_HI);

    logic in_region;
    logic fail;

    always_comb begin
        in_region = (addr >= LO) && (addr <= HI);
        fail      = rd_en && in_region && (^data);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ParityErr <= 1'b0;
            ErrAddr   <= '0;
            ErrCount  <= '0;
        end else begin
            ParityErr <= fail;
            if (fail) begin
                ErrAddr <= addr;
                if (ErrCount != 8'hFF) begin
                    ErrCount <= ErrCount + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the data memory between the CPU core and the host port.
// Fixed CPU priority with a starvation guard, bus locking, registered read return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int PAR_LO     = PAR_LO_DEF,
    parameter int PAR_HI     = PAR_HI_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          CpuReq,
    input  logic          CpuWe,
    input  logic          CpuLock,
    input  logic [AW-1:0] CpuAddr,
    input  logic [DW-1:0] CpuWdata,
    output logic          CpuGnt,
    output logic [DW-1:0] CpuRdata,
    output logic          CpuRvalid,
    input  logic          HostReq,
    input  logic          HostWe,
    input  logic          HostLock,
    input  logic [AW-1:0] HostAddr,
    input  logic [DW-1:0] HostWdata,
    output logic          HostGnt,
    output logic [DW-1:0] HostRdata,
    output logic          HostRvalid,
    output logic [AW-1:0] MemAddress,
    output logic [DW-1:0] MemDataIn,
    output logic          MemWriteEn,
    input  logic [DW-1:0] MemDataOut,
    output logic          ParityErr,
    output logic [AW-1:0] ErrAddr,
    output logic [7:0]    ErrCount
);

    localparam int            SW   = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    arb_state_t    state, state_nxt;
    logic [SW-1:0] starve, starve_nxt;
    logic          cpu_rd, host_rd;

    // A lock only shields its owner while it keeps requesting; once it drops Req
    // the cycle falls through to normal arbitration so the other side is not stalled.
    always_comb begin
        CpuGnt  = 1'b0;
        HostGnt = 1'b0;
        if (Reset) begin
            if (state == ARB_CPU_LOCK && CpuReq) begin
                CpuGnt = 1'b1;
            end else if (state == ARB_HOST_LOCK && HostReq) begin
                HostGnt = 1'b1;
            end else if (CpuReq && !(HostReq && starve == SMAX)) begin
                CpuGnt = 1'b1;
            end else if (HostReq) begin
                HostGnt = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = ARB_IDLE;
        if (CpuGnt && CpuLock) begin
            state_nxt = ARB_CPU_LOCK;
        end else if (HostGnt && HostLock) begin
            state_nxt = ARB_HOST_LOCK;
        end

        starve_nxt = starve;
        if (HostGnt || !HostReq) begin
            starve_nxt = '0;
        end else if (CpuGnt && starve != SMAX) begin
            starve_nxt = starve + 1'b1;
        end
    end

    always_comb begin
        MemAddress = '0;
        MemDataIn  = '0;
        if (CpuGnt) begin
            MemAddress = CpuAddr;
            MemDataIn  = CpuWdata;
        end else if (HostGnt) begin
            MemAddress = HostAddr;
            MemDataIn  = HostWdata;
        end
        MemWriteEn = (CpuGnt && CpuWe) || (HostGnt && HostWe);
        cpu_rd     = CpuGnt && !CpuWe;
        host_rd    = HostGnt && !HostWe;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= ARB_IDLE;
            starve     <= '0;
            CpuRdata   <= '0;
            CpuRvalid  <= 1'b0;
            HostRdata  <= '0;
            HostRvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve     <= starve_nxt;
            CpuRvalid  <= cpu_rd;
            HostRvalid <= host_rd;
            if (cpu_rd) begin
                CpuRdata <= MemDataOut;
            end
            if (host_rd) begin
                HostRdata <= MemDataOut;
            end
        end
    end

    dmem_parity_chk #(
        .AW     (AW),
        .DW     (DW),
        .PAR_LO (PAR_LO),
        .PAR_HI (PAR_HI)
    ) u_parity (
        .Clk       (Clk),
        .Reset     (Reset),
        .rd_en     (cpu_rd || host_rd),
        .addr      (MemAddress),
        .data      (MemDataOut),
        .ParityErr (ParityErr),
        .ErrAddr   (ErrAddr),
        .ErrCount  (ErrCount)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x8 memory behind it.
// Vector table for single-cycle arbitration plus hand sequences for multi-cycle cases.
module tb_dmem_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       CpuReq, CpuWe, CpuLock;
    logic [7:0] CpuAddr, CpuWdata;
    logic       CpuGnt, CpuRvalid;
    logic [7:0] CpuRdata;
    logic       HostReq, HostWe, HostLock;
    logic [7:0] HostAddr, HostWdata;
    logic       HostGnt, HostRvalid;
    logic [7:0] HostRdata;
    logic [7:0] MemAddress, MemDataIn, MemDataOut;
    logic       MemWriteEn;
    logic       ParityErr;
    logic [7:0] ErrAddr, ErrCount;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256] = '{default: 8'h00};

    always #5 Clk = ~Clk;

    assign MemDataOut = mem[MemAddress];
    always @(posedge Clk) if (MemWriteEn) mem[MemAddress] <= MemDataIn;

    dmem_arbiter #(
        .AW(8), .DW(8), .STARVE_MAX(4), .PAR_LO(64), .PAR_HI(127)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuLock(CpuLock),
        .CpuAddr(CpuAddr), .CpuWdata(CpuWdata),
        .CpuGnt(CpuGnt), .CpuRdata(CpuRdata), .CpuRvalid(CpuRvalid),
        .HostReq(HostReq), .HostWe(HostWe), .HostLock(HostLock),
        .HostAddr(HostAddr), .HostWdata(HostWdata),
        .HostGnt(HostGnt), .HostRdata(HostRdata), .HostRvalid(HostRvalid),
        .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemWriteEn(MemWriteEn),
        .MemDataOut(MemDataOut),
        .ParityErr(ParityErr), .ErrAddr(ErrAddr), .ErrCount(ErrCount)
    );

    // cc/hc = {Req,We,Lock}; eg = {CpuGnt,HostGnt,MemWriteEn}; erv = {CpuRvalid,HostRvalid}
    typedef struct {
        logic [2:0] cc;
        logic [7:0] ca, cd;
        logic [2:0] hc;
        logic [7:0] ha, hd;
        logic [2:0] eg;
        logic [7:0] ema, emd;
        logic [1:0] erv;
        logic [7:0] ecrd, ehrd;
    } vec_t;

    vec_t tbl [11];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_all();
        {CpuReq, CpuWe, CpuLock}    = 3'b000;
        {HostReq, HostWe, HostLock} = 3'b000;
        CpuAddr = 8'h00; CpuWdata = 8'h00;
        HostAddr = 8'h00; HostWdata = 8'h00;
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        {HostReq, HostWe, HostLock} = 3'b110;
        HostAddr = a; HostWdata = d;
        cyc();
        {HostReq, HostWe, HostLock} = 3'b000;
        HostWdata = 8'h00;
    endtask

    task automatic host_rd(input logic [7:0] a);
        {HostReq, HostWe, HostLock} = 3'b100;
        HostAddr = a;
        cyc();
        HostReq = 1'b0;
    endtask

    initial begin
        logic [9:0] host_pat;

        tbl[0]  = '{3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00};
        tbl[1]  = '{3'b110, 8'h10, 8'h33, 3'b000, 8'h00, 8'h00, 3'b101, 8'h10, 8'h33, 2'b00, 8'h00, 8'h00};
        tbl[2]  = '{3'b000, 8'h00, 8'h00, 3'b100, 8'h10, 8'h00, 3'b010, 8'h10, 8'h00, 2'b00, 8'h00, 8'h00};
        tbl[3]  = '{3'b100, 8'h10, 8'h00, 3'b100, 8'h20, 8'h00, 3'b100, 8'h10, 8'h00, 2'b01, 8'h00, 8'h33};
        tbl[4]  = '{3'b100, 8'h20, 8'h00, 3'b100, 8'h20, 8'h00, 3'b100, 8'h20, 8'h00, 2'b10, 8'h33, 8'h33};
        tbl[5]  = '{3'b000, 8'h00, 8'h00, 3'b100, 8'h20, 8'h00, 3'b010, 8'h20, 8'h00, 2'b10, 8'h00, 8'h33};
        tbl[6]  = '{3'b110, 8'h21, 8'hA5, 3'b110, 8'h22, 8'h44, 3'b101, 8'h21, 8'hA5, 2'b01, 8'h00, 8'h00};
        tbl[7]  = '{3'b000, 8'h00, 8'h00, 3'b110, 8'h22, 8'h44, 3'b011, 8'h22, 8'h44, 2'b00, 8'h00, 8'h00};
        tbl[8]  = '{3'b100, 8'h22, 8'h00, 3'b100, 8'h21, 8'h00, 3'b100, 8'h22, 8'h00, 2'b00, 8'h00, 8'h00};
        tbl[9]  = '{3'b000, 8'h00, 8'h00, 3'b100, 8'h21, 8'h00, 3'b010, 8'h21, 8'h00, 2'b10, 8'h44, 8'h00};
        tbl[10] = '{3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 2'b01, 8'h44, 8'hA5};

        idle_all();
        Reset = 1'b0;
        #1;
        chk1("rst CpuGnt", CpuGnt, 1'b0);
        chk1("rst HostRvalid", HostRvalid, 1'b0);
        chk8("rst ErrCount", ErrCount, 8'h00);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;

        // single-cycle vector table
        for (int i = 0; i < 11; i++) begin
            {CpuReq, CpuWe, CpuLock}    = tbl[i].cc;
            {HostReq, HostWe, HostLock} = tbl[i].hc;
            CpuAddr = tbl[i].ca;  CpuWdata = tbl[i].cd;
            HostAddr = tbl[i].ha; HostWdata = tbl[i].hd;
            #1;
            chk1($sformatf("v%0d CpuGnt", i), CpuGnt, tbl[i].eg[2]);
            chk1($sformatf("v%0d HostGnt", i), HostGnt, tbl[i].eg[1]);
            chk1($sformatf("v%0d MemWriteEn", i), MemWriteEn, tbl[i].eg[0]);
            chk8($sformatf("v%0d MemAddress", i), MemAddress, tbl[i].ema);
            chk8($sformatf("v%0d MemDataIn", i), MemDataIn, tbl[i].emd);
            chk1($sformatf("v%0d CpuRvalid", i), CpuRvalid, tbl[i].erv[1]);
            chk1($sformatf("v%0d HostRvalid", i), HostRvalid, tbl[i].erv[0]);
            chk8($sformatf("v%0d CpuRdata", i), CpuRdata, tbl[i].ecrd);
            chk8($sformatf("v%0d HostRdata", i), HostRdata, tbl[i].ehrd);
            @(posedge Clk);
            #1;
        end

        // contention: C,C,C,C,H,C,C,C,C,H
        host_pat = 10'b10000_10000;
        {CpuReq, HostReq} = 2'b11;
        CpuAddr = 8'h00; HostAddr = 8'h01;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk1($sformatf("contend%0d CpuGnt", i), CpuGnt, ~host_pat[i]);
            chk1($sformatf("contend%0d HostGnt", i), HostGnt, host_pat[i]);
            cyc();
        end
        idle_all();
        cyc();

        // CPU lock holds off a starved host until the unlocking write
        {CpuReq, CpuWe, CpuLock} = 3'b101;
        CpuAddr = 8'h90;
        HostReq = 1'b1; HostAddr = 8'h90;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1($sformatf("lock%0d CpuGnt", i), CpuGnt, 1'b1);
            chk1($sformatf("lock%0d HostGnt", i), HostGnt, 1'b0);
            cyc();
        end
        {CpuWe, CpuLock} = 2'b10;
        CpuWdata = 8'h5A;
        #1;
        chk1("lock wr CpuGnt", CpuGnt, 1'b1);
        chk1("lock wr HostGnt", HostGnt, 1'b0);
        chk1("lock wr MemWriteEn", MemWriteEn, 1'b1);
        cyc();
        {CpuReq, CpuWe} = 2'b00;
        CpuWdata = 8'h00;
        #1;
        chk1("after unlock HostGnt", HostGnt, 1'b1);
        cyc();
        HostReq = 1'b0;
        #1;
        chk1("lock rd HostRvalid", HostRvalid, 1'b1);
        chk8("lock rd HostRdata", HostRdata, 8'h5A);
        cyc();

        // lock released by dropping Req: host served in that same cycle
        {CpuReq, CpuWe, CpuLock} = 3'b101;
        CpuAddr = 8'h91;
        HostReq = 1'b1; HostAddr = 8'h91;
        #1;
        chk1("lockdrop CpuGnt", CpuGnt, 1'b1);
        cyc();
        {CpuReq, CpuLock} = 2'b00;
        #1;
        chk1("lockdrop HostGnt", HostGnt, 1'b1);
        cyc();
        idle_all();
        cyc();

        // read latency after host write
        {HostReq, HostWe} = 2'b11;
        HostAddr = 8'hA0; HostWdata = 8'h55;
        #1;
        chk1("lat wr HostGnt", HostGnt, 1'b1);
        cyc();
        HostWe = 1'b0; HostWdata = 8'h00;
        #1;
        chk1("lat rd HostGnt", HostGnt, 1'b1);
        chk1("lat wr no HostRvalid", HostRvalid, 1'b0);
        cyc();
        HostReq = 1'b0;
        chk1("lat HostRvalid", HostRvalid, 1'b1);
        chk8("lat HostRdata", HostRdata, 8'h55);
        chk1("lat CpuRvalid", CpuRvalid, 1'b0);
        cyc();
        chk1("lat pulse end", HostRvalid, 1'b0);
        chk8("lat HostRdata hold", HostRdata, 8'h55);

        // parity region
        host_wr(8'h40, 8'hC1);
        chk1("par wr no err", ParityErr, 1'b0);
        host_rd(8'h40);
        chk1("par 40 ParityErr", ParityErr, 1'b1);
        chk1("par 40 HostRvalid", HostRvalid, 1'b1);
        chk8("par 40 HostRdata", HostRdata, 8'hC1);
        chk8("par 40 ErrAddr", ErrAddr, 8'h40);
        chk8("par 40 ErrCount", ErrCount, 8'h01);
        cyc();
        chk1("par pulse end", ParityErr, 1'b0);
        host_wr(8'h80, 8'hC1);
        host_rd(8'h80);
        chk1("par 80 ParityErr", ParityErr, 1'b0);
        chk8("par 80 HostRdata", HostRdata, 8'hC1);
        host_wr(8'h40, 8'h41);
        host_rd(8'h40);
        chk1("par 41 ParityErr", ParityErr, 1'b0);
        chk8("par 41 ErrCount", ErrCount, 8'h01);
        host_wr(8'h7F, 8'hC1);
        host_rd(8'h7F);
        chk1("par 7F ParityErr", ParityErr, 1'b1);
        chk8("par 7F ErrAddr", ErrAddr, 8'h7F);
        chk8("par 7F ErrCount", ErrCount, 8'h02);
        host_wr(8'h3F, 8'hC1);
        host_rd(8'h3F);
        chk1("par 3F ParityErr", ParityErr, 1'b0);
        chk8("par 3F ErrAddr", ErrAddr, 8'h7F);

        // 300 back-to-back failing reads saturate the counter
        {CpuReq, CpuWe, CpuLock} = 3'b100;
        CpuAddr = 8'h7F;
        for (int i = 0; i < 300; i++) begin
            cyc();
            chk1($sformatf("b2b%0d CpuRvalid", i), CpuRvalid, 1'b1);
        end
        CpuReq = 1'b0;
        chk8("sat ErrCount", ErrCount, 8'hFF);
        chk8("sat ErrAddr", ErrAddr, 8'h7F);
        cyc();

        // reset while CPU holds the lock with a read return pending
        {CpuReq, CpuWe, CpuLock} = 3'b101;
        CpuAddr = 8'h7F;
        HostReq = 1'b1; HostAddr = 8'h50;
        #1;
        chk1("rstlock CpuGnt", CpuGnt, 1'b1);
        @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk1("rstlock CpuGnt0", CpuGnt, 1'b0);
        chk1("rstlock HostGnt0", HostGnt, 1'b0);
        chk1("rstlock CpuRvalid", CpuRvalid, 1'b0);
        chk1("rstlock HostRvalid", HostRvalid, 1'b0);
        chk8("rstlock CpuRdata", CpuRdata, 8'h00);
        chk8("rstlock HostRdata", HostRdata, 8'h00);
        chk1("rstlock ParityErr", ParityErr, 1'b0);
        chk8("rstlock ErrAddr", ErrAddr, 8'h00);
        chk8("rstlock ErrCount", ErrCount, 8'h00);
        chk1("rstlock MemWriteEn", MemWriteEn, 1'b0);
        chk8("rstlock MemAddress", MemAddress, 8'h00);
        chk8("rstlock MemDataIn", MemDataIn, 8'h00);
        {CpuReq, CpuLock} = 2'b00;
        #1 Reset = 1'b1;
        #1;
        chk1("postrst HostGnt", HostGnt, 1'b1);
        chk1("postrst CpuGnt", CpuGnt, 1'b0);
        cyc();
        HostReq = 1'b0;
        chk1("postrst HostRvalid", HostRvalid, 1'b1);
        chk1("postrst ParityErr", ParityErr, 1'b0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the 256x8 data memory. Shares the memory's single combinational-read / synchronous-write port between the CPU core and a host port (loader/debug/DMA). Provides fixed priority with a starvation guard, bus locking for read-modify-write sequences, registered read return, and parity checking of the parity-protected region. Sits between the core's load/store unit and the data memory, driving the memory's address, write-enable and write-data inputs.

## Interface
- AW, 8: address width
- DW, 8: data width
- STARVE_MAX, 4: consecutive CPU wins over a waiting host before the host is forced through
- PAR_LO, 64: first address of the parity region
- PAR_HI, 127: last address of the parity region

- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low reset
- CpuReq, CpuWe, CpuLock  in  1 each  CPU request, write select, hold grant next cycle
- CpuAddr  in  AW  CPU address
- CpuWdata  in  DW  CPU write data
- CpuGnt  out  1  CPU transaction accepted this cycle
- CpuRdata  out  DW  CPU read data, registered
- CpuRvalid  out  1  CpuRdata valid, one-cycle pulse
- HostReq, HostWe, HostLock, HostAddr, HostWdata, HostGnt, HostRdata, HostRvalid: same as the Cpu* ports, host side
- MemAddress  out  AW  to memory address
- MemDataIn  out  DW  to memory write data
- MemWriteEn  out  1  to memory write enable
- MemDataOut  in  DW  from memory combinational read data
- ParityErr  out  1  one-cycle pulse, coincident with the Rvalid of a failing read
- ErrAddr  out  AW  address of the most recent parity failure
- ErrCount  out  8  parity failures, saturates at 255

## Operation
- Transaction completes in the cycle where Req && Gnt. At most one Gnt per cycle. A requester holds Req/We/Addr/Wdata stable until Gnt.
- FSM states: ARB_IDLE, ARB_CPU_LOCK, ARB_HOST_LOCK.
- ARB_IDLE: CPU wins if CpuReq, unless HostReq && starve == STARVE_MAX, in which case the host wins. Otherwise the host wins if HostReq.
- Granted with Lock=1: next state is the matching *_LOCK state. Granted with Lock=0, or no grant: ARB_IDLE.
- ARB_x_LOCK: only x may be granted, and only when xReq. The other side waits and starvation does not preempt. Leave when x is granted with Lock=0, or when xReq=0 (go to ARB_IDLE that cycle, arbitrate as IDLE).
- starve counter, 0..STARVE_MAX, saturating: increment when CPU granted while HostReq; clear on any host grant or when HostReq=0.
- Memory drive: MemAddress/MemDataIn come from the granted side, else 0. MemWriteEn = Gnt && We.
- Reads: MemDataOut captured into the granted side's Rdata at the clock edge. Rvalid pulses the next cycle. Rdata holds until the next read to that side. Writes produce no Rvalid.
- Parity: a granted read with PAR_LO <= addr <= PAR_HI fails if ^MemDataOut != 0 (region stores 7-bit data, bit 7 = ^bits[6:0]). On failure: ParityErr pulse with Rvalid, ErrAddr latched, ErrCount++ (saturating). Data is returned unmodified. Writes are not checked.

## Timing
- Gnt and Mem* are combinational from Req/We/Addr/Wdata, FSM state and starve. There is no path from MemDataOut to any Gnt.
- Read latency: 1 cycle (Gnt edge to Rvalid). Back-to-back reads give Rvalid every cycle.
- Write takes effect at the Gnt cycle's clock edge. A read of the same address granted the next cycle returns the new data.
- Reset asserted (any time, mid-lock included): FSM ARB_IDLE, starve 0, all Gnt 0, Rvalid 0, Rdata 0, ParityErr 0, ErrAddr 0, ErrCount 0, MemWriteEn 0, MemAddress 0, MemDataIn 0. A pending Rvalid is dropped. Memory contents are not this block's responsibility.

## Structure
- Package dmem_arb_pkg: arb_state_t enum (ARB_IDLE, ARB_CPU_LOCK, ARB_HOST_LOCK), PAR_LO/PAR_HI defaults, STARVE_MAX default.
- Sub-module dmem_parity_chk: region compare, parity evaluation, ParityErr/ErrAddr/ErrCount registers. The arbiter FSM, starve counter and read capture stay in dmem_arbiter.

## Test plan
- Reset mid-lock: CPU locks, assert Reset -> all outputs 0, FSM IDLE. After release, HostReq is granted immediately.
- Contention: CpuReq and HostReq both held continuously, STARVE_MAX=4 -> grant sequence C,C,C,C,H,C,C,C,C,H. No cycle with both Gnt.
- Lock: CPU reads 0x90 with CpuLock=1, then writes 0x90 with Lock=0, HostReq high throughout -> host first granted the cycle after the write. Host read of 0x90 returns the written value.
- Read latency: host writes 0x55 to 0xA0, then reads 0xA0 -> HostRvalid exactly 1 cycle after the read Gnt, HostRdata=0x55, CpuRvalid stays 0.
- Parity: memory returns 0xC1 on a read of 0x40 -> ParityErr pulse, ErrAddr=0x40, ErrCount=1. Same data from 0x80 -> no error. 0x41 from 0x40 -> no error.
- Saturation: 300 failing reads -> ErrCount=255.
